// File: rtl/axis_fifo_burst_ctrl.sv
// Burst scheduler: holds an AXI-Stream FIFO back until a full burst is stored, then passes it with tlast.
// Optional stalled partial-burst flush is built in when AXIS_FIFO_BURST_CTRL_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module axis_fifo_burst_ctrl #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int CNTR_WIDTH       = 16,
  parameter int TIMEOUT_WIDTH    = 16
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [CNTR_WIDTH-1:0]       cfg_burst_len,
`ifdef AXIS_FIFO_BURST_CTRL_TIMEOUT_EN
  input  logic [TIMEOUT_WIDTH-1:0]    cfg_timeout,
`endif
  input  logic [31:0]                 fifo_read_count,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic                        m_axis_tlast,
  output logic [31:0]                 sts_burst_count,
  output logic                        busy
);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t                state_reg, state_next;
  logic [CNTR_WIDTH-1:0] remaining_reg, remaining_next;
  logic [31:0]           burst_count_reg, burst_count_next;
  logic [31:0]           burst_len_ext;
  logic                  burst_ready;
  logic                  flush;

  assign burst_len_ext = 32'(cfg_burst_len);
  assign burst_ready   = (cfg_burst_len != '0) && (fifo_read_count >= burst_len_ext);

`ifdef AXIS_FIFO_BURST_CTRL_TIMEOUT_EN
  logic [TIMEOUT_WIDTH-1:0] timer_reg, timer_next;
  logic                     stall_window;

  // Only a non-empty FIFO below threshold counts as stalled; any other condition restarts the timer.
  assign stall_window = (state_reg == IDLE) && (fifo_read_count != 32'd0) &&
                        (fifo_read_count < burst_len_ext);
  assign flush        = stall_window && (cfg_timeout != '0) && (timer_reg >= cfg_timeout);

  always_comb begin
    timer_next = '0;
    if (stall_window && !flush && (timer_reg != '1)) begin
      timer_next = timer_reg + 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      timer_reg <= '0;
    end else begin
      timer_reg <= timer_next;
    end
  end
`else
  assign flush = 1'b0;
`endif

  always_comb begin
    state_next       = state_reg;
    remaining_next   = remaining_reg;
    burst_count_next = burst_count_reg;
    s_axis_tready    = 1'b0;
    m_axis_tvalid    = 1'b0;
    m_axis_tlast     = 1'b0;
    busy             = 1'b0;
    m_axis_tdata     = s_axis_tdata;

    case (state_reg)
      IDLE: begin
        // A full burst takes priority over a flush on the same cycle.
        if (burst_ready) begin
          remaining_next = cfg_burst_len;
          state_next     = STREAM;
        end else if (flush) begin
          remaining_next = fifo_read_count[CNTR_WIDTH-1:0];
          state_next     = STREAM;
        end
      end
      STREAM: begin
        busy          = 1'b1;
        m_axis_tvalid = s_axis_tvalid;
        s_axis_tready = m_axis_tready;
        m_axis_tlast  = (remaining_reg == CNTR_WIDTH'(1));
        if (s_axis_tvalid && m_axis_tready) begin
          remaining_next = remaining_reg - 1'b1;
          if (remaining_reg == CNTR_WIDTH'(1)) begin
            burst_count_next = burst_count_reg + 32'd1;
            state_next       = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_reg       <= IDLE;
      remaining_reg   <= '0;
      burst_count_reg <= '0;
    end else begin
      state_reg       <= state_next;
      remaining_reg   <= remaining_next;
      burst_count_reg <= burst_count_next;
    end
  end

  assign sts_burst_count = burst_count_reg;

endmodule

// File: tb/tb_axis_fifo_burst_ctrl.sv
// Self-checking bench for axis_fifo_burst_ctrl: queue-based FIFO model feeding the DUT, per-scenario tasks.
// Timeout scenario is compiled in when AXIS_FIFO_BURST_CTRL_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_axis_fifo_burst_ctrl;

  localparam int W  = 32;
  localparam int CW = 16;
  localparam int TW = 16;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic [CW-1:0] cfg_burst_len = '0;
`ifdef AXIS_FIFO_BURST_CTRL_TIMEOUT_EN
  logic [TW-1:0] cfg_timeout = '0;
`endif
  logic [31:0]   fifo_read_count = '0;
  logic [W-1:0]  s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic [W-1:0]  m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b0;
  logic          m_axis_tlast;
  logic [31:0]   sts_burst_count;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_bursts = 0;

  logic [W-1:0] fifo_q[$];
  logic [W-1:0] exp_q[$];

  logic         obs_xfer, obs_last, obs_valid, obs_busy, obs_sready;
  logic [W-1:0] obs_data;

  always #5 aclk = ~aclk;

  axis_fifo_burst_ctrl #(
    .AXIS_TDATA_WIDTH(W),
    .CNTR_WIDTH(CW),
    .TIMEOUT_WIDTH(TW)
  ) dut (
    .aclk(aclk),
    .aresetn(aresetn),
    .cfg_burst_len(cfg_burst_len),
`ifdef AXIS_FIFO_BURST_CTRL_TIMEOUT_EN
    .cfg_timeout(cfg_timeout),
`endif
    .fifo_read_count(fifo_read_count),
    .s_axis_tdata(s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast),
    .sts_burst_count(sts_burst_count),
    .busy(busy)
  );

  task automatic push_word();
    logic [W-1:0] d;
    d = W'($urandom());
    fifo_q.push_back(d);
    exp_q.push_back(d);
  endtask

  // One clock cycle: present the FIFO model, record outputs, pop on handshake, advance to edge+1.
  task automatic tick();
    s_axis_tvalid   = (fifo_q.size() != 0);
    s_axis_tdata    = (fifo_q.size() != 0) ? fifo_q[0] : W'($urandom());
    fifo_read_count = 32'(fifo_q.size());
    #1;
    obs_valid  = m_axis_tvalid;
    obs_sready = s_axis_tready;
    obs_busy   = busy;
    obs_last   = m_axis_tlast;
    obs_data   = m_axis_tdata;
    obs_xfer   = m_axis_tvalid && m_axis_tready;
    if (s_axis_tvalid && s_axis_tready) void'(fifo_q.pop_front());
    if (obs_xfer) $display("xfer data=%08h last=%0b bursts=%0d", obs_data, obs_last, sts_burst_count);
    @(posedge aclk);
    #1;
  endtask

  task automatic test_reset();
    aresetn = 1'b0; cfg_burst_len = 16'd4; m_axis_tready = 1'b1;
    s_axis_tvalid = 1'b1; s_axis_tdata = 32'hA5A5_1234; fifo_read_count = 32'd9;
    #3;
    n_checks++;
    if ({m_axis_tvalid, s_axis_tready, m_axis_tlast, busy} !== 4'b0000) begin
      n_fail++; $display("FAIL rst_outputs: got %b want 0000", {m_axis_tvalid, s_axis_tready, m_axis_tlast, busy});
    end
    n_checks++;
    if (sts_burst_count !== 32'd0) begin
      n_fail++; $display("FAIL rst_count: got %0d want 0", sts_burst_count);
    end
    n_checks++;
    if (m_axis_tdata !== 32'hA5A5_1234) begin
      n_fail++; $display("FAIL rst_tdata: got %08h want a5a51234", m_axis_tdata);
    end
    @(posedge aclk); #1;
    aresetn = 1'b1;
    repeat (3) push_word();
    for (int c = 0; c < 100; c++) begin
      tick();
      n_checks++;
      if ({obs_valid, obs_sready, obs_last, obs_busy} !== 4'b0000) begin
        n_fail++; $display("FAIL below_thr c=%0d: got %b want 0000", c, {obs_valid, obs_sready, obs_last, obs_busy});
      end
    end
    n_checks++;
    if (sts_burst_count !== 32'd0) begin
      n_fail++; $display("FAIL below_thr_count: got %0d want 0", sts_burst_count);
    end
  endtask

  task automatic test_threshold();
    push_word();
    m_axis_tready = 1'b1;
    tick();
    n_checks++;
    if (obs_valid !== 1'b0) begin
      n_fail++; $display("FAIL thr_latency: tvalid got %b want 0", obs_valid);
    end
    for (int c = 1; c <= 4; c++) begin
      tick();
      n_checks++;
      if (obs_xfer !== 1'b1 || obs_busy !== 1'b1) begin
        n_fail++; $display("FAIL thr_xfer c=%0d: xfer %b busy %b want 1 1", c, obs_xfer, obs_busy);
      end else begin
        n_checks++;
        if (obs_data !== exp_q[0]) begin
          n_fail++; $display("FAIL thr_data c=%0d: got %08h want %08h", c, obs_data, exp_q[0]);
        end
        void'(exp_q.pop_front());
        n_checks++;
        if (obs_last !== (c == 4)) begin
          n_fail++; $display("FAIL thr_last c=%0d: got %b want %b", c, obs_last, c == 4);
        end
      end
    end
    exp_bursts++;
    tick();
    n_checks++;
    if (obs_busy !== 1'b0 || obs_valid !== 1'b0) begin
      n_fail++; $display("FAIL thr_idle: busy %b valid %b want 0 0", obs_busy, obs_valid);
    end
    n_checks++;
    if (sts_burst_count !== 32'(exp_bursts)) begin
      n_fail++; $display("FAIL thr_count: got %0d want %0d", sts_burst_count, exp_bursts);
    end
  endtask

  task automatic test_toggle();
    int n = 0;
    cfg_burst_len = 16'd8;
    repeat (8) push_word();
    for (int c = 0; c < 40; c++) begin
      m_axis_tready = (c % 2 == 0);
      tick();
      if (obs_xfer) begin
        n++;
        n_checks++;
        if (obs_data !== exp_q[0]) begin
          n_fail++; $display("FAIL tog_data n=%0d: got %08h want %08h", n, obs_data, exp_q[0]);
        end
        void'(exp_q.pop_front());
        n_checks++;
        if (obs_last !== (n == 8)) begin
          n_fail++; $display("FAIL tog_last n=%0d: got %b want %b", n, obs_last, n == 8);
        end
      end
    end
    exp_bursts++;
    n_checks++;
    if (n != 8) begin
      n_fail++; $display("FAIL tog_count: got %0d transfers want 8", n);
    end
    n_checks++;
    if (sts_burst_count !== 32'(exp_bursts)) begin
      n_fail++; $display("FAIL tog_bursts: got %0d want %0d", sts_burst_count, exp_bursts);
    end
  endtask

  task automatic test_cfg_change();
    int lens[2] = '{4, 2};
    int bi = 0, beat = 0, n = 0;
    cfg_burst_len = 16'd4; m_axis_tready = 1'b1;
    repeat (6) push_word();
    for (int c = 0; c < 30; c++) begin
      tick();
      if (obs_xfer) begin
        n++; beat++;
        n_checks++;
        if (obs_data !== exp_q[0]) begin
          n_fail++; $display("FAIL cfg_data n=%0d: got %08h want %08h", n, obs_data, exp_q[0]);
        end
        void'(exp_q.pop_front());
        n_checks++;
        if (obs_last !== (bi < 2 && beat == lens[bi])) begin
          n_fail++; $display("FAIL cfg_last n=%0d: got %b want %b", n, obs_last, bi < 2 && beat == lens[bi]);
        end
        if (n == 1) cfg_burst_len = 16'd2;
        if (bi < 2 && beat == lens[bi]) begin
          bi++; beat = 0; exp_bursts++;
        end
      end
    end
    n_checks++;
    if (n != 6) begin
      n_fail++; $display("FAIL cfg_count: got %0d transfers want 6", n);
    end
    n_checks++;
    if (sts_burst_count !== 32'(exp_bursts)) begin
      n_fail++; $display("FAIL cfg_bursts: got %0d want %0d", sts_burst_count, exp_bursts);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    cfg_burst_len = 16'd4; m_axis_tready = 1'b1;
    repeat (4) push_word();
    repeat (3) begin
      tick();
      if (obs_xfer) n++;
    end
    n_checks++;
    if (n != 2 || obs_busy !== 1'b1) begin
      n_fail++; $display("FAIL mid_pre: got %0d transfers busy %b want 2 1", n, obs_busy);
    end
    #2;
    aresetn = 1'b0;
    #1;
    n_checks++;
    if ({m_axis_tvalid, s_axis_tready, m_axis_tlast, busy} !== 4'b0000) begin
      n_fail++; $display("FAIL mid_async: got %b want 0000", {m_axis_tvalid, s_axis_tready, m_axis_tlast, busy});
    end
    n_checks++;
    if (sts_burst_count !== 32'd0) begin
      n_fail++; $display("FAIL mid_count: got %0d want 0", sts_burst_count);
    end
    @(posedge aclk); #1;
    aresetn = 1'b1;
    fifo_q.delete(); exp_q.delete();
    exp_bursts = 0;
  endtask

  task automatic test_disabled();
    int active = 0;
    cfg_burst_len = '0; m_axis_tready = 1'b1;
    repeat (5) push_word();
    repeat (20) begin
      tick();
      if (obs_busy !== 1'b0 || obs_valid !== 1'b0) active++;
    end
    n_checks++;
    if (active != 0) begin
      n_fail++; $display("FAIL len0_idle: got %0d active cycles want 0", active);
    end
    fifo_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      int len, total, want;
      int pushed = 0, n = 0, beat = 0, cyc = 0;
      len   = (r == 0) ? 1 : int'($urandom_range(2, 7));
      total = int'($urandom_range(len, 4 * len + 3));
      want  = (total / len) * len;
      cfg_burst_len = CW'(len);
      while ((pushed < total || n < want) && cyc < 2000) begin
        if (pushed < total && $urandom_range(0, 1) == 1) begin
          push_word(); pushed++;
        end
        m_axis_tready = 1'($urandom_range(0, 1));
        tick();
        cyc++;
        if (obs_xfer) begin
          n++; beat++;
          n_checks++;
          if (obs_data !== exp_q[0]) begin
            n_fail++; $display("FAIL rnd_data r=%0d n=%0d: got %08h want %08h", r, n, obs_data, exp_q[0]);
          end
          void'(exp_q.pop_front());
          n_checks++;
          if (obs_last !== (beat == len)) begin
            n_fail++; $display("FAIL rnd_last r=%0d n=%0d: got %b want %b", r, n, obs_last, beat == len);
          end
          if (beat == len) begin
            beat = 0; exp_bursts++;
          end
        end
      end
      n_checks++;
      if (cyc >= 2000) begin
        n_fail++; $display("FAIL rnd_timeout r=%0d: got %0d transfers want %0d", r, n, want);
      end
      repeat (5) begin
        m_axis_tready = 1'b1;
        tick();
        if (obs_xfer) n++;
      end
      n_checks++;
      if (n != want) begin
        n_fail++; $display("FAIL rnd_total r=%0d len=%0d: got %0d want %0d", r, len, n, want);
      end
      n_checks++;
      if (sts_burst_count !== 32'(exp_bursts)) begin
        n_fail++; $display("FAIL rnd_bursts r=%0d: got %0d want %0d", r, sts_burst_count, exp_bursts);
      end
      n_checks++;
      if (fifo_q.size() != total % len || obs_busy !== 1'b0) begin
        n_fail++; $display("FAIL rnd_left r=%0d: got %0d words busy %b want %0d 0", r, fifo_q.size(), obs_busy, total % len);
      end
      fifo_q.delete(); exp_q.delete();
    end
  endtask

`ifdef AXIS_FIFO_BURST_CTRL_TIMEOUT_EN
  task automatic test_timeout();
    int first = -1, n = 0;
    fifo_q.delete(); exp_q.delete();
    tick(); tick();
    cfg_burst_len = 16'd16; cfg_timeout = 16'd10; m_axis_tready = 1'b1;
    repeat (5) push_word();
    for (int c = 0; c < 30; c++) begin
      tick();
      if (obs_valid === 1'b1 && first < 0) first = c;
      if (obs_xfer) begin
        n++;
        n_checks++;
        if (obs_data !== exp_q[0]) begin
          n_fail++; $display("FAIL to_data n=%0d: got %08h want %08h", n, obs_data, exp_q[0]);
        end
        void'(exp_q.pop_front());
        n_checks++;
        if (obs_last !== (n == 5)) begin
          n_fail++; $display("FAIL to_last n=%0d: got %b want %b", n, obs_last, n == 5);
        end
      end
    end
    exp_bursts++;
    n_checks++;
    if (first != 11) begin
      n_fail++; $display("FAIL to_start: got cycle %0d want 11", first);
    end
    n_checks++;
    if (n != 5) begin
      n_fail++; $display("FAIL to_count: got %0d transfers want 5", n);
    end
    n_checks++;
    if (sts_burst_count !== 32'(exp_bursts)) begin
      n_fail++; $display("FAIL to_bursts: got %0d want %0d", sts_burst_count, exp_bursts);
    end
    cfg_timeout = '0;
  endtask
`endif

  initial begin
    test_reset();
    test_threshold();
    test_toggle();
    test_cfg_change();
    test_reset_mid();
    test_disabled();
    test_random();
`ifdef AXIS_FIFO_BURST_CTRL_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axis_fifo_burst_ctrl.md
# axis_fifo_burst_ctrl

Burst scheduler placed between an AXI-Stream FIFO's master port and a packet-oriented consumer such as a DMA writer. It holds back the stream until the FIFO reports at least one full burst of stored words. It then passes exactly that many words with `tlast` on the final one, and counts completed bursts. An optional timeout flushes a partial burst when the FIFO has stalled below the threshold.

## Interface
Parameters:
- `AXIS_TDATA_WIDTH`, 32, data width of both stream ports
- `CNTR_WIDTH`, 16, width of burst length and remaining-word counter
- `TIMEOUT_WIDTH`, 16, width of flush timer; used only with the timeout feature

Ports:
- `aclk`  in  1  clock; all logic on rising edge
- `aresetn`  in  1  reset, asynchronous, active-low
- `cfg_burst_len`  in  CNTR_WIDTH  words per burst; 0 disables bursting
- `cfg_timeout`  in  TIMEOUT_WIDTH  idle cycles before flush; 0 disables flush; port exists only with the timeout feature
- `fifo_read_count`  in  32  words currently readable from the upstream FIFO
- `s_axis_tdata`  in  AXIS_TDATA_WIDTH  data from FIFO
- `s_axis_tvalid`  in  1  FIFO data valid
- `s_axis_tready`  out  1  read strobe to FIFO
- `m_axis_tdata`  out  AXIS_TDATA_WIDTH  data to consumer
- `m_axis_tvalid`  out  1  output valid
- `m_axis_tready`  in  1  consumer ready
- `m_axis_tlast`  out  1  final word of burst
- `sts_burst_count`  out  32  completed bursts, wraps at 2^32
- `busy`  out  1  high while a burst is in progress

## Operation
- States: IDLE and STREAM, held in a registered state bit.
- IDLE:
  - `s_axis_tready` = 0, `m_axis_tvalid` = 0, `m_axis_tlast` = 0.
  - If `cfg_burst_len` != 0 and `fifo_read_count` >= zero-extended `cfg_burst_len`, then on the next edge: `remaining` <= `cfg_burst_len` and go to STREAM.
- STREAM:
  - `busy` = 1. Combinational pass-through:
    - `m_axis_tdata` = `s_axis_tdata`
    - `m_axis_tvalid` = `s_axis_tvalid`
    - `s_axis_tready` = `m_axis_tready`
    - `m_axis_tlast` = (`remaining` == 1)
  - Transfer occurs when `s_axis_tvalid` and `m_axis_tready` are both high; each transfer decrements `remaining`.
  - A transfer with `remaining` == 1 increments `sts_burst_count` and returns to IDLE on the same edge.
- `cfg_burst_len` is sampled only at burst start. Changes during STREAM take effect at the next burst.
- Stalls on either side inside STREAM are legal. State and `remaining` are held until a transfer occurs.
- The threshold decision uses only `fifo_read_count`, and only this block drains the FIFO. Starved `s_axis_tvalid` during a burst is therefore a system error; the block simply waits.

## Timing
- Reset (asynchronous, immediate):
  - state = IDLE, `remaining` = 0, `sts_burst_count` = 0, timer = 0.
  - All outputs low: `s_axis_tready`, `m_axis_tvalid`, `m_axis_tlast`, `busy` = 0; `m_axis_tdata` follows `s_axis_tdata`.
- Reset asserted mid-burst abandons the burst; no `tlast` is emitted.
- Latency:
  - 1 cycle from threshold met to first possible `m_axis_tvalid`.
  - Zero-cycle data path within STREAM.
  - After the last transfer, IDLE is held for at least 1 cycle before the next burst can start. Maximum throughput is N words per N+1 cycles.
- `busy` is combinationally equal to (state == STREAM).
- `cfg_burst_len` = 1: a single word per burst, with `tlast` high on that word.

## Configuration
- Macro: `AXIS_FIFO_BURST_CTRL_TIMEOUT_EN`.
- Defined:
  - The `cfg_timeout` port and a TIMEOUT_WIDTH timer are present.
  - The timer runs in IDLE while 0 < `fifo_read_count` < `cfg_burst_len`, and clears otherwise and on entry to STREAM.
  - When `cfg_timeout` != 0 and the timer reaches `cfg_timeout`, the next edge loads `remaining` <= `fifo_read_count[CNTR_WIDTH-1:0]` and enters STREAM. This value is guaranteed to be below `cfg_burst_len`.
  - The short burst ends with `tlast` and also increments `sts_burst_count`.
  - A threshold burst and a timeout on the same cycle: the full burst wins.
- Undefined:
  - No `cfg_timeout` port and no timer.
  - Partial data remains in the FIFO indefinitely.

## Test plan
- Reset, `cfg_burst_len`=4, `fifo_read_count`=3: all outputs stay low for 100 cycles and `sts_burst_count`=0.
- Count rises to 4 with `m_axis_tready`=1: 4 words are passed on consecutive cycles, starting 1 cycle after the threshold, with `tlast` on the 4th; `sts_burst_count`=1.
- `m_axis_tready` toggled 1/0 during an 8-word burst: exactly 8 transfers, data order preserved, `tlast` only on the 8th.
- `cfg_burst_len` changed from 4 to 2 after the 1st word of a burst: the current burst still has 4 words and the next burst has 2.
- `aresetn` pulsed low after 2 of 4 words: outputs drop to 0 immediately without waiting for a clock edge; `sts_burst_count`=0 and `busy`=0.
- With the macro defined, `cfg_timeout`=10, `cfg_burst_len`=16, count held at 5: a 5-word burst with `tlast` starts 11 cycles after the count first becomes nonzero; `sts_burst_count`=1.
